// File: rtl/bp_resolve_queue.sv
// In-order queue of in-flight branch predictions; resolves them against execute,
// drives the 2-bit predictor update port, squashes on mispredict, keeps accuracy stats.
module bp_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pred_valid,
    output logic                     pred_ready,
    input  logic                     pred_taken,
    input  logic [PC_W-1:0]          pred_pc,
    input  logic                     res_valid,
    input  logic                     res_taken,
    input  logic [PC_W-1:0]          res_pc,
    input  logic                     flush,
    output logic                     upd_en,
    output logic                     upd_result,
    output logic [PC_W-1:0]          upd_pc,
    output logic                     mispredict,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         total_cnt,
    output logic [CNT_W-1:0]         miss_cnt,
    output logic                     err_orphan,
    output logic                     err_tag
);
    localparam int              AW     = $clog2(DEPTH);
    localparam logic [AW:0]     L_FULL = (AW+1)'(DEPTH);

    logic [PC_W-1:0]  r_pc_mem [DEPTH];
    logic [DEPTH-1:0] r_tk_mem;
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [AW:0]      r_count;

    logic             r_upd_en;
    logic             r_upd_result;
    logic [PC_W-1:0]  r_upd_pc;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_total_cnt;
    logic [CNT_W-1:0] r_miss_cnt;
    logic             r_err_orphan;
    logic             r_err_tag;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_miss;
    logic             w_clear;
    logic             w_push;
    logic [PC_W-1:0]  w_head_pc;
    logic             w_head_tk;

    assign w_full    = (r_count == L_FULL);
    assign w_empty   = (r_count == '0);
    assign w_head_pc = r_pc_mem[r_head];
    assign w_head_tk = r_tk_mem[r_head];
    assign w_pop     = res_valid && !w_empty;
    assign w_miss    = w_pop && (w_head_tk != res_taken);
    // A mispredict or flush makes any same-cycle push wrong-path, so it never lands.
    assign w_clear   = flush || w_miss;
    assign w_push    = pred_valid && !w_full && !w_clear;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_tail] <= pred_pc;
            r_tk_mem[r_tail] <= pred_taken;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_upd_en     <= 1'b0;
            r_upd_result <= 1'b0;
            r_upd_pc     <= '0;
            r_mispredict <= 1'b0;
            r_total_cnt  <= '0;
            r_miss_cnt   <= '0;
            r_err_orphan <= 1'b0;
            r_err_tag    <= 1'b0;
        end else begin
            r_upd_en     <= w_pop;
            r_mispredict <= w_miss;
            if (w_pop) begin
                r_upd_result <= res_taken;
                r_upd_pc     <= w_head_pc;
                if (r_total_cnt != '1) r_total_cnt <= r_total_cnt + CNT_W'(1);
                if (res_pc != w_head_pc) r_err_tag <= 1'b1;
            end
            if (w_miss && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            if (res_valid && w_empty) r_err_orphan <= 1'b1;

            if (w_clear) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_tail <= r_tail + AW'(1);
                if (w_pop)  r_head <= r_head + AW'(1);
                if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
                else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
            end
        end
    end

    assign pred_ready = !w_full;
    assign full       = w_full;
    assign empty      = w_empty;
    assign count      = r_count;
    assign upd_en     = r_upd_en;
    assign upd_result = r_upd_result;
    assign upd_pc     = r_upd_pc;
    assign mispredict = r_mispredict;
    assign total_cnt  = r_total_cnt;
    assign miss_cnt   = r_miss_cnt;
    assign err_orphan = r_err_orphan;
    assign err_tag    = r_err_tag;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Scoreboard bench for bp_resolve_queue: resolves queue expected update pulses,
// a negedge monitor pops and compares them; state/counters checked inline.
module tb_bp_resolve_queue;
    localparam int DEPTH = 8;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              pred_valid, pred_taken, res_valid, res_taken, flush;
    logic [PC_W-1:0]   pred_pc, res_pc;
    logic              pred_ready, upd_en, upd_result, mispredict, full, empty;
    logic [PC_W-1:0]   upd_pc;
    logic [3:0]        count;
    logic [CNT_W-1:0]  total_cnt, miss_cnt;
    logic              err_orphan, err_tag;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic            res;
        logic [PC_W-1:0] pc;
        logic            miss;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    bp_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .res_valid(res_valid), .res_taken(res_taken), .res_pc(res_pc), .flush(flush),
        .upd_en(upd_en), .upd_result(upd_result), .upd_pc(upd_pc), .mispredict(mispredict),
        .full(full), .empty(empty), .count(count),
        .total_cnt(total_cnt), .miss_cnt(miss_cnt),
        .err_orphan(err_orphan), .err_tag(err_tag)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; returns 1ns after the edge so registered results are visible.
    task automatic step(input logic pv, input logic pt, input logic [PC_W-1:0] ppc,
                        input logic rv, input logic rt, input logic [PC_W-1:0] rpc,
                        input logic fl);
        pred_valid = pv; pred_taken = pt; pred_pc = ppc;
        res_valid = rv; res_taken = rt; res_pc = rpc; flush = fl;
        @(posedge clk);
        #1;
        pred_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic push(input logic tk, input logic [PC_W-1:0] pc);
        step(1'b1, tk, pc, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic resolve(input logic tk, input logic [PC_W-1:0] rpc,
                           input logic [PC_W-1:0] head_pc, input logic exp_miss);
        sb.push_back('{res: tk, pc: head_pc, miss: exp_miss});
        step(1'b0, 1'b0, '0, 1'b1, tk, rpc, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (upd_en) begin
                if (sb.size() == 0) begin
                    chk("upd_en_unexpected", {63'd0, upd_en}, 64'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("upd_result", {63'd0, upd_result}, {63'd0, e.res});
                    chk("upd_pc", {32'd0, upd_pc}, {32'd0, e.pc});
                    chk("mispredict", {63'd0, mispredict}, {63'd0, e.miss});
                end
            end else if (mispredict) begin
                chk("mispredict_without_en", {63'd0, mispredict}, 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pred_valid = 1'b0; pred_taken = 1'b0; pred_pc = '0;
        res_valid = 1'b0; res_taken = 1'b0; res_pc = '0; flush = 1'b0;
        #12;
        chk("rst_empty", {63'd0, empty}, 64'd1);
        chk("rst_ready", {63'd0, pred_ready}, 64'd1);
        chk("rst_full", {63'd0, full}, 64'd0);
        chk("rst_count", {60'd0, count}, 64'd0);
        chk("rst_upd_en", {63'd0, upd_en}, 64'd0);
        chk("rst_total", {60'd0, total_cnt}, 64'd0);
        chk("rst_errs", {62'd0, err_orphan, err_tag}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // In-order, all correctly predicted
        push(1'b1, 32'h100);
        push(1'b0, 32'h104);
        push(1'b1, 32'h108);
        chk("t1_count", {60'd0, count}, 64'd3);
        resolve(1'b1, 32'h100, 32'h100, 1'b0);
        resolve(1'b0, 32'h104, 32'h104, 1'b0);
        resolve(1'b1, 32'h108, 32'h108, 1'b0);
        chk("t1_total", {60'd0, total_cnt}, 64'd3);
        chk("t1_miss", {60'd0, miss_cnt}, 64'd0);
        chk("t1_empty", {63'd0, empty}, 64'd1);

        // Mispredict squashes the younger entry
        push(1'b0, 32'h200);
        push(1'b1, 32'h204);
        resolve(1'b1, 32'h200, 32'h200, 1'b1);
        chk("t2_empty", {63'd0, empty}, 64'd1);
        chk("t2_count", {60'd0, count}, 64'd0);
        chk("t2_total", {60'd0, total_cnt}, 64'd4);
        chk("t2_miss", {60'd0, miss_cnt}, 64'd1);

        // Fill to DEPTH, drop when full, push+pop at full and below full
        for (int i = 0; i < DEPTH; i++) push(i[0], 32'h300 + 32'(4 * i));
        chk("t3_full", {63'd0, full}, 64'd1);
        chk("t3_ready", {63'd0, pred_ready}, 64'd0);
        chk("t3_count8", {60'd0, count}, 64'd8);
        push(1'b1, 32'h400);
        chk("t3_drop", {60'd0, count}, 64'd8);
        sb.push_back('{res: 1'b0, pc: 32'h300, miss: 1'b0});
        step(1'b1, 1'b1, 32'h500, 1'b1, 1'b0, 32'h300, 1'b0);
        chk("t3_pushpop_full", {60'd0, count}, 64'd7);
        sb.push_back('{res: 1'b1, pc: 32'h304, miss: 1'b0});
        step(1'b1, 1'b0, 32'h504, 1'b1, 1'b1, 32'h304, 1'b0);
        chk("t3_pushpop_7", {60'd0, count}, 64'd7);
        push(1'b1, 32'h508);
        chk("t3_refill", {60'd0, count}, 64'd8);
        for (int k = 0; k < DEPTH; k++) begin
            logic [PC_W-1:0] pc;
            pc = (k < 6) ? 32'h308 + 32'(4 * k) : ((k == 6) ? 32'h504 : 32'h508);
            resolve(k[0], pc, pc, 1'b0);
        end
        chk("t3_empty", {63'd0, empty}, 64'd1);
        chk("t3_total", {60'd0, total_cnt}, 64'd14);
        chk("t3_miss", {60'd0, miss_cnt}, 64'd1);

        // Resolve on empty: no pulse, sticky orphan, same-cycle push still enqueues
        step(1'b1, 1'b1, 32'h600, 1'b1, 1'b1, 32'h600, 1'b0);
        chk("t4_orphan", {63'd0, err_orphan}, 64'd1);
        chk("t4_count", {60'd0, count}, 64'd1);
        chk("t4_total", {60'd0, total_cnt}, 64'd14);
        resolve(1'b1, 32'h600, 32'h600, 1'b0);
        chk("t4_orphan_sticky", {63'd0, err_orphan}, 64'd1);
        chk("t4_total15", {60'd0, total_cnt}, 64'd15);

        // Flush with resolve and push: head still resolves, push discarded
        push(1'b0, 32'h700);
        push(1'b1, 32'h704);
        push(1'b0, 32'h708);
        sb.push_back('{res: 1'b0, pc: 32'h700, miss: 1'b0});
        step(1'b1, 1'b1, 32'h70C, 1'b1, 1'b0, 32'h700, 1'b1);
        chk("t6_count", {60'd0, count}, 64'd0);
        chk("t6_empty", {63'd0, empty}, 64'd1);
        chk("t6_total_sat", {60'd0, total_cnt}, 64'd15);

        // Tag mismatch: resolved against head regardless
        chk("t7_tag_clear", {63'd0, err_tag}, 64'd0);
        push(1'b1, 32'h800);
        resolve(1'b1, 32'h804, 32'h800, 1'b0);
        chk("t7_tag", {63'd0, err_tag}, 64'd1);

        // Saturation of the miss counter
        for (int j = 0; j < 20; j++) begin
            push(1'b0, 32'h900 + 32'(4 * j));
            resolve(1'b1, 32'h900 + 32'(4 * j), 32'h900 + 32'(4 * j), 1'b1);
        end
        chk("t5_total", {60'd0, total_cnt}, 64'd15);
        chk("t5_miss", {60'd0, miss_cnt}, 64'd15);
        chk("t7_tag_sticky", {63'd0, err_tag}, 64'd1);

        // Asynchronous reset mid-operation
        push(1'b1, 32'hA00);
        push(1'b0, 32'hA04);
        chk("t8_count_pre", {60'd0, count}, 64'd2);
        rst = 1'b1;
        #1;
        chk("t8_count", {60'd0, count}, 64'd0);
        chk("t8_empty", {63'd0, empty}, 64'd1);
        chk("t8_errs", {62'd0, err_orphan, err_tag}, 64'd0);
        chk("t8_counters", {56'd0, total_cnt, miss_cnt}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
